// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared FSM state type for the GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// rtl/gcd_step.sv - one combinational Euclid step: swap when a<b, otherwise subtract.
module gcd_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             b_zero,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b
);

    logic             a_lt_b;
    logic [WIDTH-1:0] diff;

    assign b_zero = (b == '0);
    assign a_lt_b = (a < b);
    // Only taken when a >= b, so the subtraction never wraps.
    assign diff   = a - b;
    assign next_a = a_lt_b ? b : diff;
    assign next_b = a_lt_b ? a : b;

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - handshaked subtract/swap GCD engine with abort.
// Optional CALC cycle counter on cycles_o when GCD_CYCLE_CNT_EN is defined.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = WIDTH + 2
) (
`ifdef GCD_CYCLE_CNT_EN
    output logic [CNT_W-1:0] cycles_o,
`endif
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             abort_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o,
    output logic             busy_o
);

    if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_param_check
        $error("gcd_engine: WIDTH must be 2..32 and CNT_W at least 1");
    end

    gcd_state_t       state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             b_zero;
    logic             accept;

    assign accept = in_valid_i && in_ready_o && !abort_i;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .b      (b),
        .b_zero (b_zero),
        .next_a (next_a),
        .next_b (next_b)
    );

    // in_ready_o resets low and rises on the first edge spent in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            result_o    <= '0;
            err_o       <= 1'b0;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_o <= 1'b1;
                    if (accept) begin
                        a          <= op_a_i;
                        b          <= op_b_i;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        busy_o     <= 1'b0;
                        in_ready_o <= 1'b1;
                        state      <= IDLE;
                    end else if (b_zero) begin
                        // a can only be zero here if both operands were zero.
                        result_o    <= a;
                        err_o       <= (a == '0);
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        a <= next_a;
                        b <= next_b;
                    end
                end
                DONE: begin
                    if (abort_i || out_ready_i) begin
                        out_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    in_ready_o  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycles_o <= '0;
        end else if (state == IDLE && accept) begin
            cycles_o <= '0;
        end else if (state == CALC && cycles_o != '1) begin
            cycles_o <= cycles_o + CNT_W'(1);
        end
    end
`endif

endmodule
